// File: rtl/bf16_mul_sched.sv
// Two-requester round-robin scheduler feeding a 3-stage BF16 multiplier with tagged, backpressured results.
// Optional performance counters are compiled in when BF16_SCHED_PERF_EN is defined.
module bf16_mul_sched #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [15:0]      r0_a,
  input  logic [15:0]      r0_b,
  input  logic [1:0]       r0_prec,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [15:0]      r1_a,
  input  logic [15:0]      r1_b,
  input  logic [1:0]       r1_prec,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_id,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       res_flags
`ifdef BF16_SCHED_PERF_EN
  ,
  output logic [15:0]      perf_r0_ops,
  output logic [15:0]      perf_r1_ops,
  output logic [15:0]      perf_stall
`endif
);

  function automatic logic [6:0] prec_mask(input logic [1:0] p);
    case (p)
      2'd0:    prec_mask = 7'h7F;
      2'd1:    prec_mask = 7'h7C;
      2'd2:    prec_mask = 7'h70;
      default: prec_mask = 7'h40;
    endcase
  endfunction

  // Returns {overflow, underflow, bf16}; truncates the fraction and saturates the exponent.
  function automatic logic [17:0] pack_result(input logic s, input logic signed [9:0] e,
                                              input logic [10:0] m, input logic zero,
                                              input logic inf);
    logic signed [9:0] en;
    logic [6:0]        frac;
    en   = m[10] ? e + 10'sd1 : e;
    frac = 7'((m >> m[10]) >> 2);
    if (zero)                        pack_result = {2'b00, s, 15'h0000};
    else if (inf || en >= 10'sd255)  pack_result = {2'b10, s, 8'hFF, 7'h00};
    else if (en <= 10'sd0)           pack_result = {2'b01, s, 15'h0000};
    else                             pack_result = {2'b00, s, en[7:0], frac};
  endfunction

  logic                    r_last;
  logic                    w_adv;
  logic                    w_gnt_vld;
  logic                    w_gnt;
  logic                    w_acc;
  logic [15:0]             w_a;
  logic [15:0]             w_b;
  logic [1:0]              w_prec;
  logic [TAG_W-1:0]        w_tag;
  logic [7:0]              w_ea;
  logic [7:0]              w_eb;
  logic signed [9:0]       w_exp_s1;
  logic                    w_zero_s1;
  logic                    w_inf_s1;
  logic [10:0]             w_mant_s2;
  logic [17:0]             w_pack_s3;

  logic                    r_vld_p0;
  logic                    r_id_p0;
  logic [TAG_W-1:0]        r_tag_p0;
  logic                    r_sign_p0;
  logic signed [9:0]       r_exp_p0;
  logic [6:0]              r_fa_p0;
  logic [6:0]              r_fb_p0;
  logic                    r_zero_p0;
  logic                    r_inf_p0;

  logic                    r_vld_p1;
  logic                    r_id_p1;
  logic [TAG_W-1:0]        r_tag_p1;
  logic                    r_sign_p1;
  logic signed [9:0]       r_exp_p1;
  logic [10:0]             r_mant_p1;
  logic                    r_zero_p1;
  logic                    r_inf_p1;

  logic                    r_res_valid;
  logic [15:0]             r_res_data;
  logic                    r_res_id;
  logic [TAG_W-1:0]        r_res_tag;
  logic [1:0]              r_res_flags;

  assign w_adv = !r_res_valid || res_ready;

  // Round-robin: when both request, the one that did not win last time goes.
  always_comb begin
    w_gnt_vld = r0_valid || r1_valid;
    if (r0_valid && r1_valid) w_gnt = ~r_last;
    else                      w_gnt = r1_valid && !r0_valid;
  end

  assign w_acc    = w_adv && w_gnt_vld;
  assign r0_ready = w_acc && !w_gnt;
  assign r1_ready = w_acc && w_gnt;

  assign w_a    = w_gnt ? r1_a    : r0_a;
  assign w_b    = w_gnt ? r1_b    : r0_b;
  assign w_prec = w_gnt ? r1_prec : r0_prec;
  assign w_tag  = w_gnt ? r1_tag  : r0_tag;

  // Stage 1: unpack, special-case classification, biased exponent sum
  assign w_ea      = w_a[14:7];
  assign w_eb      = w_b[14:7];
  assign w_zero_s1 = (w_ea == 8'h00) || (w_eb == 8'h00);
  assign w_inf_s1  = !w_zero_s1 && ((w_ea == 8'hFF) || (w_eb == 8'hFF));
  assign w_exp_s1  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

  // Stage 2: mantissa multiply, keeping the top 11 product bits
  assign w_mant_s2 = 11'((16'({1'b1, r_fa_p0}) * 16'({1'b1, r_fb_p0})) >> 5);

  // Stage 3: normalize, saturate and pack
  assign w_pack_s3 = pack_result(r_sign_p1, r_exp_p1, r_mant_p1, r_zero_p1, r_inf_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= 1'b1;
      r_vld_p0    <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= 1'b0;
      r_res_tag   <= '0;
      r_res_flags <= '0;
    end else begin
      if (w_acc) r_last <= w_gnt;
      if (w_adv) begin
        r_vld_p0                  <= w_acc;
        r_vld_p1                  <= r_vld_p0;
        r_res_valid               <= r_vld_p1;
        {r_res_flags, r_res_data} <= w_pack_s3;
        r_res_id                  <= r_id_p1;
        r_res_tag                 <= r_tag_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_id_p0   <= w_gnt;
      r_tag_p0  <= w_tag;
      r_sign_p0 <= w_a[15] ^ w_b[15];
      r_exp_p0  <= w_exp_s1;
      r_fa_p0   <= w_a[6:0] & prec_mask(w_prec);
      r_fb_p0   <= w_b[6:0] & prec_mask(w_prec);
      r_zero_p0 <= w_zero_s1;
      r_inf_p0  <= w_inf_s1;

      r_id_p1   <= r_id_p0;
      r_tag_p1  <= r_tag_p0;
      r_sign_p1 <= r_sign_p0;
      r_exp_p1  <= r_exp_p0;
      r_mant_p1 <= w_mant_s2;
      r_zero_p1 <= r_zero_p0;
      r_inf_p1  <= r_inf_p0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_tag   = r_res_tag;
  assign res_flags = r_res_flags;

`ifdef BF16_SCHED_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [15:0] r_perf_r0_ops;
  logic [15:0] r_perf_r1_ops;
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_r0_ops <= '0;
      r_perf_r1_ops <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (r0_valid && r0_ready)      r_perf_r0_ops <= sat_inc(r_perf_r0_ops);
      if (r1_valid && r1_ready)      r_perf_r1_ops <= sat_inc(r_perf_r1_ops);
      if (r_res_valid && !res_ready) r_perf_stall  <= sat_inc(r_perf_stall);
    end
  end

  assign perf_r0_ops = r_perf_r0_ops;
  assign perf_r1_ops = r_perf_r1_ops;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_bf16_mul_sched.sv
// Scoreboard bench for bf16_mul_sched: handshakes push reference results, a monitor pops and compares.
module tb_bf16_mul_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [15:0] r0_a, r0_b, r1_a, r1_b;
  logic [1:0]  r0_prec, r1_prec;
  logic [3:0]  r0_tag, r1_tag;
  logic        res_valid, res_ready, res_id;
  logic [15:0] res_data;
  logic [3:0]  res_tag;
  logic [1:0]  res_flags;
`ifdef BF16_SCHED_PERF_EN
  logic [15:0] perf_r0_ops, perf_r1_ops, perf_stall;
`endif

  always #5 clk = ~clk;

  bf16_mul_sched #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_prec(r0_prec), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_prec(r1_prec), .r1_tag(r1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_tag(res_tag), .res_flags(res_flags)
`ifdef BF16_SCHED_PERF_EN
    , .perf_r0_ops(perf_r0_ops), .perf_r1_ops(perf_r1_ops), .perf_stall(perf_stall)
`endif
  );

  typedef struct {
    logic [15:0] d;
    logic [1:0]  f;
    logic        id;
    logic [3:0]  tag;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0, hs_cyc = 0, last_cyc = 0;
  int          n_push = 0, n_res = 0;
  logic [15:0] last_d;
  logic [1:0]  last_f;
  logic        last_id;
  logic [3:0]  last_tag;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: real-valued BF16 multiply with truncated fraction, done in integer arithmetic.
  function automatic logic [17:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] p);
    int ea, eb, keep, mask, ma, mb, prod, e, frac;
    logic s;
    s    = a[15] ^ b[15];
    ea   = int'(a[14:7]);
    eb   = int'(b[14:7]);
    keep = 7 - 2 * int'(p);
    mask = 128 - (1 << (7 - keep));
    if (ea == 0 || eb == 0)     return {2'b00, s, 15'h0000};
    if (ea == 255 || eb == 255) return {2'b10, s, 15'h7F80};
    ma   = 128 + (int'(a[6:0]) & mask);
    mb   = 128 + (int'(b[6:0]) & mask);
    prod = ma * mb;
    if (prod >= 32768) begin
      e    = ea + eb - 126;
      frac = (prod >> 8) & 127;
    end else begin
      e    = ea + eb - 127;
      frac = (prod >> 7) & 127;
    end
    if (e >= 255) return {2'b10, s, 15'h7F80};
    if (e <= 0)   return {2'b01, s, 15'h0000};
    return {2'b00, s, e[7:0], frac[6:0]};
  endfunction

  function automatic exp_t mk_exp(input logic id, input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] p, input logic [3:0] t);
    exp_t        x;
    logic [17:0] r;
    r     = ref_mul(a, b, p);
    x.d   = r[15:0];
    x.f   = r[17:16];
    x.id  = id;
    x.tag = t;
    return x;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (r0_valid && r0_ready) begin q.push_back(mk_exp(1'b0, r0_a, r0_b, r0_prec, r0_tag)); n_push++; end
      if (r1_valid && r1_ready) begin q.push_back(mk_exp(1'b1, r1_a, r1_b, r1_prec, r1_tag)); n_push++; end
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL res_unexpected: got data %h tag %h, expected no result", res_data, res_tag);
        end else begin
          e = q.pop_front();
          chk("res_id_tag_flags_data", 32'({res_id, res_tag, res_flags, res_data}),
              32'({e.id, e.tag, e.f, e.d}));
        end
        last_d   = res_data;
        last_f   = res_flags;
        last_id  = res_id;
        last_tag = res_tag;
        last_cyc = cyc;
        n_res++;
      end
    end
  end

  task automatic drive(input int id, input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] p, input logic [3:0] t);
    if (id == 0) begin
      r0_valid = v; r0_a = a; r0_b = b; r0_prec = p; r0_tag = t;
    end else begin
      r1_valid = v; r1_a = a; r1_b = b; r1_prec = p; r1_tag = t;
    end
  endtask

  task automatic send(input int id, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] p, input logic [3:0] t);
    int k;
    @(posedge clk); #1;
    drive(id, 1'b1, a, b, p, t);
    k = 0;
    forever begin
      @(negedge clk);
      if (id == 0 ? r0_ready : r1_ready) break;
      k++;
      if (k > 100) begin
        n_vec++; n_err++;
        $display("FAIL handshake_timeout: requester %0d not accepted in 100 cycles, expected ready", id);
        break;
      end
    end
    hs_cyc = cyc;
    @(posedge clk); #1;
    drive(id, 1'b0, a, b, p, t);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (q.size() != 0 || res_valid) begin
      @(negedge clk);
      k++;
      if (k > 300) begin
        n_vec++; n_err++;
        $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
        break;
      end
    end
  endtask

  task automatic dir(input int id, input logic [15:0] a, input logic [15:0] b, input logic [1:0] p,
                     input logic [3:0] t, input logic [15:0] ed, input logic [1:0] ef, input string nm);
    send(id, a, b, p, t);
    wait_drain();
    chk({nm, "_data"}, 32'(last_d), 32'(ed));
    chk({nm, "_flags"}, 32'(last_f), 32'(ef));
    chk({nm, "_id"}, 32'(last_id), id);
    chk({nm, "_tag"}, 32'(last_tag), 32'(t));
    chk({nm, "_latency"}, last_cyc - hs_cyc, 3);
  endtask

  function automatic logic [15:0] rand_op();
    int          r;
    logic [7:0]  e;
    r = $urandom_range(0, 9);
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'd255;
    else if (r == 2) e = 8'($urandom_range(1, 20));
    else if (r == 3) e = 8'($urandom_range(235, 254));
    else             e = 8'($urandom_range(100, 154));
    return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
  endfunction

  task automatic drv(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(id, rand_op(), rand_op(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end
  endtask

  logic        rnd_done;
  logic [22:0] held;
  int          g;
`ifdef BF16_SCHED_PERF_EN
  logic [15:0] b0, b1, bs;
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; res_ready = 1'b1; rnd_done = 1'b0;
    drive(0, 1'b0, 16'h0, 16'h0, 2'd0, 4'd0);
    drive(1, 1'b0, 16'h0, 16'h0, 2'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_res_outputs", 32'({res_id, res_tag, res_flags, res_data}), 32'd0);
    chk("reset_readys", 32'({r0_ready, r1_ready}), 32'd0);
`ifdef BF16_SCHED_PERF_EN
    chk("reset_perf", 32'(perf_r0_ops | perf_r1_ops | perf_stall), 32'd0);
`endif
    rst_n = 1'b1;

    dir(0, 16'h3FC0, 16'h3FC0, 2'd0, 4'd5, 16'h4010, 2'b00, "basic_1p5sq");
    dir(0, 16'h3F80, 16'h3F80, 2'd0, 4'd1, 16'h3F80, 2'b00, "basic_one");
    dir(1, 16'h3FFF, 16'h3F80, 2'd3, 4'd2, 16'h3FC0, 2'b00, "prec3");
    dir(1, 16'h3FFF, 16'h3F80, 2'd0, 4'd3, 16'h3FFF, 2'b00, "prec0");
    dir(0, 16'h7F00, 16'h7F00, 2'd0, 4'd4, 16'h7F80, 2'b10, "overflow");
    dir(1, 16'h0080, 16'h0080, 2'd0, 4'd6, 16'h0000, 2'b01, "underflow");
    dir(0, 16'h0000, 16'h7F80, 2'd0, 4'd7, 16'h0000, 2'b00, "zero_vs_inf");
    dir(0, 16'h7F80, 16'h3F80, 2'd0, 4'd8, 16'h7F80, 2'b10, "inf");
    dir(1, 16'hBF80, 16'h3F80, 2'd1, 4'd9, 16'hBF80, 2'b00, "neg_one");

    // Both requesters streaming: grants alternate starting with requester 0.
    @(posedge clk); #1;
    drive(0, 1'b1, rand_op(), rand_op(), 2'd0, 4'd0);
    drive(1, 1'b1, rand_op(), rand_op(), 2'd0, 4'd8);
`ifdef BF16_SCHED_PERF_EN
    b0 = perf_r0_ops; b1 = perf_r1_ops;
`endif
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      g = r0_ready ? (r1_ready ? 3 : 0) : (r1_ready ? 1 : 2);
      chk("arb_grant", g, k % 2);
      @(posedge clk); #1;
      if (g == 0) drive(0, 1'b1, rand_op(), rand_op(), 2'($urandom_range(0, 3)), r0_tag + 4'd1);
      if (g == 1) drive(1, 1'b1, rand_op(), rand_op(), 2'($urandom_range(0, 3)), r1_tag + 4'd1);
    end
`ifdef BF16_SCHED_PERF_EN
    chk("perf_r0_ops_delta", 32'(perf_r0_ops - b0), 32'd4);
    chk("perf_r1_ops_delta", 32'(perf_r1_ops - b1), 32'd4);
    bs = perf_stall;
`endif

    // Four stalled cycles with both requesters still valid.
    res_ready = 1'b0;
    @(negedge clk);
    chk("stall_res_valid", 32'(res_valid), 32'd1);
    held = {res_id, res_tag, res_flags, res_data};
    chk("stall_readys", 32'({r0_ready, r1_ready}), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", 32'({res_id, res_tag, res_flags, res_data}), 32'(held));
      chk("stall_readys", 32'({r0_ready, r1_ready}), 32'd0);
    end
    @(posedge clk); #1;
`ifdef BF16_SCHED_PERF_EN
    chk("perf_stall_delta", 32'(perf_stall - bs), 32'd4);
`endif
    res_ready = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_drain();
    chk("stream_count", n_res, n_push);

    // Reset with three results in flight.
    res_ready = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b1, 16'h3FC0, 16'h4000, 2'd0, 4'd1);
    for (int k = 0; k < 3; k++) begin
      g = 0;
      @(negedge clk);
      while (!r0_ready && g < 20) begin @(negedge clk); g++; end
      @(posedge clk); #1;
      r0_tag = r0_tag + 4'd1;
    end
    r0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_res_valid", 32'(res_valid), 32'd0);
    chk("midreset_res_outputs", 32'({res_id, res_tag, res_flags, res_data}), 32'd0);
    q.delete();
    n_push = n_res;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
`ifdef BF16_SCHED_PERF_EN
    chk("midreset_perf", 32'(perf_r0_ops | perf_r1_ops | perf_stall), 32'd0);
`endif
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_reset_no_stale", 32'(res_valid), 32'd0);
    end

    // Randomized traffic from both requesters with random backpressure.
    fork
      begin
        fork
          drv(0, 40);
          drv(1, 40);
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_drain();
    chk("random_count", n_res, n_push);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
